soc_event_sched: RTL and testbench
==================================

Name: soc_event_sched

Overview:
Round-robin scheduler in front of the per-source SoC event queues (2-bit saturating counters, level "non-empty" output, one-cycle ack to pop).
- Picks one pending, unmasked source per grant.
- Pops that source's queue with a single-cycle ack pulse.
- Presents the source index as an event ID to the FC event unit over a valid/ready interface.
- Aggregates queue overflow errors into a sticky error flag with first-source capture.

Parameters:
NB_SOURCES, 8, number of event queues scheduled (≥2, need not be a power of 2)
ID_WIDTH, $clog2(NB_SOURCES), width of event ID and RR pointer (derived, not overridden)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
src_event_i  in  NB_SOURCES  per-queue "non-empty" level
src_ack_o  out  NB_SOURCES  per-queue pop pulse; one-hot or zero
src_err_i  in  NB_SOURCES  per-queue overflow error pulse
mask_i  in  NB_SOURCES  1 = source excluded from arbitration (queue retains its events)
evt_valid_o  out  1  event ID valid toward FC event unit
evt_id_o  out  ID_WIDTH  index of granted source
evt_ready_i  in  1  consumer accepts
err_o  out  1  sticky: any queue overflowed
err_src_o  out  ID_WIDTH  source index of first captured overflow
err_clr_i  in  1  clears err_o / err_src_o

Behaviour:
- Reset (async, rstn_i low):
  - evt_valid_o=0, evt_id_o=0, rr_ptr=0, err_o=0, err_src_o=0.
  - src_ack_o=0 while in reset.
- Eligibility: elig = src_event_i & ~mask_i.
- Output slot: single register (evt_valid_o, evt_id_o).
  - load_en = elig != 0 && (!evt_valid_o || evt_ready_i).
- Pick: lowest index i in circular order starting at rr_ptr (rr_ptr, rr_ptr+1, …, NB_SOURCES-1, 0, …) with elig[i]=1.
- On load_en in cycle t:
  - src_ack_o[i]=1 in cycle t only (combinational from registered state and inputs).
  - evt_id_o<=i and evt_valid_o<=1 at the edge ending t.
  - rr_ptr<=(i==NB_SOURCES-1) ? 0 : i+1.
- Latency: pending event on an empty slot → ack same cycle, evt_valid_o high next cycle (1 cycle).
- Throughput: with evt_ready_i held high, one event per cycle.
- Drain: handshake (valid&ready) with elig==0 → evt_valid_o<=0 next edge; evt_id_o holds its last value.
- Backpressure: evt_valid_o=1 and evt_ready_i=0 →
  - evt_id_o stable, no ack issued, rr_ptr unchanged.
  - Queues keep counting; their overflow is reported through src_err_i.
- A source stays eligible after its ack if its queue still holds events.
  - One ack decrements a queue by exactly one; with several events pending, the source is granted again only when the RR order returns to it.
  - A sole pending source is granted back-to-back.
- Mask applied the same cycle; masking never discards events. Unmasking makes pending events eligible next pick.
- rr_ptr never points outside 0..NB_SOURCES-1; wrap handled explicitly for non-power-of-2 NB_SOURCES.
- Error capture:
  - If err_o==0 and src_err_i!=0: err_o<=1, err_src_o<=lowest set index.
  - Further errors are ignored until cleared.
  - err_clr_i with a simultaneous new src_err_i: set wins; err_src_o<=lowest new index.
  - err_clr_i alone: err_o<=0, err_src_o<=0.
- Reset mid-operation: pending output is dropped and no ack is issued. Queues reset on the same rstn_i, so no event accounting is lost.

Decomposition:
- Shared package soc_event_pkg:
  - constant NB_SOC_EVENT_SOURCES.
  - typedef soc_evt_id_t (logic [ID_WIDTH-1:0]).
- One combinational sub-module soc_event_rr_pick:
  - inputs: request vector, pointer.
  - outputs: grant valid, grant index, one-hot grant.
  - implementation: double-width priority-encode over the rotated vector.
- Parent holds the output register, rr_ptr and error logic.

Test Plan:
1. src_event_i=8'b0000_0100, slot empty, ready=1 → src_ack_o=8'b0000_0100 cycle t; evt_valid_o=1, evt_id_o=2 at t+1; rr_ptr=3.
2. src_event_i=8'hFF held, rr_ptr=0, ready=1 → IDs 0,1,…,7,0 on consecutive cycles, exactly one ack bit per cycle.
3. Backpressure: ready=0 for 5 cycles with valid=1, id=4 → evt_id_o stays 4, src_ack_o=0 throughout; ready=1 → next ID issued following cycle.
4. mask_i=8'b0000_0011, src_event_i=8'b0000_0111 → only ID 2 granted; clear mask → IDs 0,1 granted afterwards with no event loss.
5. NB_SOURCES=5, rr_ptr=4, src_event_i=5'b10001 → grant 4 then 0 (wrap); rr_ptr never reaches 5.
6. src_err_i=8'b0100_1000 → err_o=1, err_src_o=3; src_err_i=8'h01 later → unchanged; err_clr_i with src_err_i=8'h20 same cycle → err_o=1, err_src_o=5.

Source files
------------

// File: rtl/soc_event_pkg.sv
// Shared constants and types for the SoC event scheduler slice.
package soc_event_pkg;

   localparam int unsigned NB_SOC_EVENT_SOURCES = 8;
   localparam int unsigned SOC_EVT_ID_WIDTH     = $clog2(NB_SOC_EVENT_SOURCES);

   typedef logic [SOC_EVT_ID_WIDTH-1:0] soc_evt_id_t;

endpackage

// File: rtl/soc_event_sched_if.sv
// Valid/ready event-ID channel from the scheduler to the FC event unit.
interface soc_event_sched_if
   import soc_event_pkg::*;
#(
   parameter int unsigned NB_SOURCES = NB_SOC_EVENT_SOURCES
);
   localparam int unsigned ID_WIDTH = $clog2(NB_SOURCES);

   logic                evt_valid;
   logic [ID_WIDTH-1:0] evt_id;
   logic                evt_ready;

   modport master (output evt_valid, output evt_id, input evt_ready);
   modport slave  (input evt_valid, input evt_id, output evt_ready);

endinterface

// File: rtl/soc_event_rr_pick.sv
// Combinational round-robin pick: first set request at or after the pointer,
// found by priority-encoding the doubled request vector shifted by the pointer.
module soc_event_rr_pick #(
   parameter int unsigned NB_SOURCES = 8
) (
   input  logic [NB_SOURCES-1:0]         req_i,
   input  logic [$clog2(NB_SOURCES)-1:0] ptr_i,
   output logic                          gnt_valid_o,
   output logic [$clog2(NB_SOURCES)-1:0] gnt_idx_o,
   output logic [NB_SOURCES-1:0]         gnt_onehot_o
);
   localparam int unsigned ID_WIDTH = $clog2(NB_SOURCES);

   logic [2*NB_SOURCES-1:0] w_dbl;
   logic [NB_SOURCES-1:0]   w_rot;
   logic [ID_WIDTH-1:0]     w_off;
   logic [ID_WIDTH:0]       w_sum;

   always_comb begin
      w_dbl       = {req_i, req_i};
      w_rot       = NB_SOURCES'(w_dbl >> ptr_i);
      w_off       = '0;
      gnt_valid_o = 1'b0;
      for (int k = int'(NB_SOURCES) - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            gnt_valid_o = 1'b1;
            w_off       = ID_WIDTH'(k);
         end
      end
      // Explicit wrap so non-power-of-2 source counts never index past the end
      w_sum = {1'b0, ptr_i} + {1'b0, w_off};
      if (w_sum >= (ID_WIDTH+1)'(NB_SOURCES)) begin
         w_sum = w_sum - (ID_WIDTH+1)'(NB_SOURCES);
      end
      gnt_idx_o    = ID_WIDTH'(w_sum);
      gnt_onehot_o = gnt_valid_o ? (NB_SOURCES'(1) << gnt_idx_o) : '0;
   end

endmodule

// File: rtl/soc_event_sched.sv
// Round-robin scheduler popping per-source event queues into a single
// event-ID output slot, plus sticky first-source overflow error capture.
module soc_event_sched
   import soc_event_pkg::*;
#(
   parameter int unsigned NB_SOURCES = NB_SOC_EVENT_SOURCES
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic [NB_SOURCES-1:0]         src_event_i,
   output logic [NB_SOURCES-1:0]         src_ack_o,
   input  logic [NB_SOURCES-1:0]         src_err_i,
   input  logic [NB_SOURCES-1:0]         mask_i,
   soc_event_sched_if.master             evt_if,
   output logic                          err_o,
   output logic [$clog2(NB_SOURCES)-1:0] err_src_o,
   input  logic                          err_clr_i
);
   localparam int unsigned ID_WIDTH = $clog2(NB_SOURCES);

   logic [NB_SOURCES-1:0] w_elig;
   logic                  w_gnt_valid;
   logic [ID_WIDTH-1:0]   w_gnt_idx;
   logic [NB_SOURCES-1:0] w_gnt_oh;
   logic                  w_load_en;
   logic [ID_WIDTH-1:0]   w_err_idx;

   logic                  r_valid;
   logic [ID_WIDTH-1:0]   r_id;
   logic [ID_WIDTH-1:0]   r_rr_ptr;
   logic                  r_err;
   logic [ID_WIDTH-1:0]   r_err_src;

   assign w_elig = src_event_i & ~mask_i;

   soc_event_rr_pick #(
      .NB_SOURCES (NB_SOURCES)
   ) u_pick (
      .req_i        (w_elig),
      .ptr_i        (r_rr_ptr),
      .gnt_valid_o  (w_gnt_valid),
      .gnt_idx_o    (w_gnt_idx),
      .gnt_onehot_o (w_gnt_oh)
   );

   assign w_load_en = w_gnt_valid && (!r_valid || evt_if.evt_ready);
   // Gated by reset so a queue is never popped while its state is being cleared
   assign src_ack_o = (w_load_en && rstn_i) ? w_gnt_oh : '0;

   always_comb begin
      w_err_idx = '0;
      for (int k = int'(NB_SOURCES) - 1; k >= 0; k--) begin
         if (src_err_i[k]) w_err_idx = ID_WIDTH'(k);
      end
   end

   // Output slot and round-robin pointer
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_valid  <= 1'b0;
         r_id     <= '0;
         r_rr_ptr <= '0;
      end else if (w_load_en) begin
         r_valid  <= 1'b1;
         r_id     <= w_gnt_idx;
         r_rr_ptr <= (w_gnt_idx == ID_WIDTH'(NB_SOURCES - 1)) ? '0 : w_gnt_idx + ID_WIDTH'(1);
      end else if (r_valid && evt_if.evt_ready) begin
         r_valid  <= 1'b0;
      end
   end

   // Sticky error: a new error wins over a simultaneous clear
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_err     <= 1'b0;
         r_err_src <= '0;
      end else if ((src_err_i != '0) && (!r_err || err_clr_i)) begin
         r_err     <= 1'b1;
         r_err_src <= w_err_idx;
      end else if (err_clr_i) begin
         r_err     <= 1'b0;
         r_err_src <= '0;
      end
   end

   assign evt_if.evt_valid = r_valid;
   assign evt_if.evt_id    = r_id;
   assign err_o            = r_err;
   assign err_src_o        = r_err_src;

endmodule

// File: tb/tb_soc_event_sched.sv
// Directed table-driven bench for soc_event_sched (8-source and 5-source builds).
module tb_soc_event_sched;

   typedef struct packed {
      logic [7:0] ev;
      logic [7:0] mask;
      logic       rdy;
      logic [7:0] err;
      logic       clr;
      logic [7:0] ack;
      logic       vld;
      logic [2:0] id;
      logic       e;
      logic [2:0] esrc;
   } vec_t;

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] ev8, mask8, err8, ack8;
   logic       clr8;
   logic       e8;
   logic [2:0] esrc8;
   logic [4:0] ev5, mask5, err5, ack5;
   logic       clr5;
   logic       e5;
   logic [2:0] esrc5;

   int total = 0;
   int bad   = 0;
   vec_t vecs[$];

   soc_event_sched_if #(.NB_SOURCES(8)) if8 ();
   soc_event_sched_if #(.NB_SOURCES(5)) if5 ();

   soc_event_sched #(.NB_SOURCES(8)) u8 (
      .clk_i(clk), .rstn_i(rstn), .src_event_i(ev8), .src_ack_o(ack8),
      .src_err_i(err8), .mask_i(mask8), .evt_if(if8.master),
      .err_o(e8), .err_src_o(esrc8), .err_clr_i(clr8)
   );

   soc_event_sched #(.NB_SOURCES(5)) u5 (
      .clk_i(clk), .rstn_i(rstn), .src_event_i(ev5), .src_ack_o(ack5),
      .src_err_i(err5), .mask_i(mask5), .evt_if(if5.master),
      .err_o(e5), .err_src_o(esrc5), .err_clr_i(clr5)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
      end
   endtask

   task automatic add(input logic [7:0] ev, input logic [7:0] mask, input logic rdy,
                      input logic [7:0] err, input logic clr, input logic [7:0] ack,
                      input logic vld, input logic [2:0] id, input logic e, input logic [2:0] esrc);
      vec_t v;
      v = '{ev: ev, mask: mask, rdy: rdy, err: err, clr: clr,
            ack: ack, vld: vld, id: id, e: e, esrc: esrc};
      vecs.push_back(v);
   endtask

   initial begin
      // Single pending source, then drain, then round-robin from pointer 3
      add(8'h00, 8'h00, 1, 8'h00, 0, 8'h00, 0, 3'd0, 0, 3'd0);
      add(8'h04, 8'h00, 1, 8'h00, 0, 8'h04, 0, 3'd0, 0, 3'd0);
      add(8'h00, 8'h00, 1, 8'h00, 0, 8'h00, 1, 3'd2, 0, 3'd0);
      add(8'hFF, 8'h00, 1, 8'h00, 0, 8'h08, 0, 3'd2, 0, 3'd0);
      add(8'hFF, 8'h00, 1, 8'h00, 0, 8'h10, 1, 3'd3, 0, 3'd0);
      for (int i = 0; i < 5; i++) add(8'hFF, 8'h00, 0, 8'h00, 0, 8'h00, 1, 3'd4, 0, 3'd0);
      add(8'hFF, 8'h00, 1, 8'h00, 0, 8'h20, 1, 3'd4, 0, 3'd0);
      add(8'hFF, 8'h00, 1, 8'h00, 0, 8'h40, 1, 3'd5, 0, 3'd0);
      add(8'hFF, 8'h00, 1, 8'h00, 0, 8'h80, 1, 3'd6, 0, 3'd0);
      add(8'hFF, 8'h00, 1, 8'h00, 0, 8'h01, 1, 3'd7, 0, 3'd0);
      add(8'hFF, 8'h00, 1, 8'h00, 0, 8'h02, 1, 3'd0, 0, 3'd0);
      add(8'h00, 8'h00, 1, 8'h00, 0, 8'h00, 1, 3'd1, 0, 3'd0);
      // Masking: only source 2 eligible, granted back-to-back; unmask releases 0 then 1
      add(8'h07, 8'h03, 1, 8'h00, 0, 8'h04, 0, 3'd1, 0, 3'd0);
      add(8'h07, 8'h03, 1, 8'h00, 0, 8'h04, 1, 3'd2, 0, 3'd0);
      add(8'h03, 8'h03, 1, 8'h00, 0, 8'h00, 1, 3'd2, 0, 3'd0);
      add(8'h03, 8'h00, 1, 8'h00, 0, 8'h01, 0, 3'd2, 0, 3'd0);
      add(8'h02, 8'h00, 1, 8'h00, 0, 8'h02, 1, 3'd0, 0, 3'd0);
      add(8'h00, 8'h00, 1, 8'h00, 0, 8'h00, 1, 3'd1, 0, 3'd0);
      // Error capture, ignore, clear-with-set, clear alone
      add(8'h00, 8'h00, 1, 8'h48, 0, 8'h00, 0, 3'd1, 0, 3'd0);
      add(8'h00, 8'h00, 1, 8'h00, 0, 8'h00, 0, 3'd1, 1, 3'd3);
      add(8'h00, 8'h00, 1, 8'h01, 0, 8'h00, 0, 3'd1, 1, 3'd3);
      add(8'h00, 8'h00, 1, 8'h20, 1, 8'h00, 0, 3'd1, 1, 3'd3);
      add(8'h00, 8'h00, 1, 8'h00, 0, 8'h00, 0, 3'd1, 1, 3'd5);
      add(8'h00, 8'h00, 1, 8'h00, 1, 8'h00, 0, 3'd1, 1, 3'd5);
      add(8'h00, 8'h00, 1, 8'h00, 0, 8'h00, 0, 3'd1, 0, 3'd0);

      rstn = 1'b0;
      ev8 = '0; mask8 = '0; err8 = '0; clr8 = 1'b0; if8.evt_ready = 1'b1;
      ev5 = '0; mask5 = '0; err5 = '0; clr5 = 1'b0; if5.evt_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      ev8 = 8'h10;
      #1;
      chk("rst_ack", -1, 32'(ack8), 32'h0);
      chk("rst_valid", -1, 32'(if8.evt_valid), 32'h0);
      chk("rst_id", -1, 32'(if8.evt_id), 32'h0);
      chk("rst_err", -1, 32'(e8), 32'h0);
      chk("rst_err_src", -1, 32'(esrc8), 32'h0);
      ev8 = '0;
      rstn = 1'b1;

      foreach (vecs[r]) begin
         @(negedge clk);
         ev8 = vecs[r].ev; mask8 = vecs[r].mask; if8.evt_ready = vecs[r].rdy;
         err8 = vecs[r].err; clr8 = vecs[r].clr;
         #1;
         chk("ack", r, 32'(ack8), 32'(vecs[r].ack));
         chk("valid", r, 32'(if8.evt_valid), 32'(vecs[r].vld));
         chk("id", r, 32'(if8.evt_id), 32'(vecs[r].id));
         chk("err", r, 32'(e8), 32'(vecs[r].e));
         chk("err_src", r, 32'(esrc8), 32'(vecs[r].esrc));
      end

      // Reset mid-operation: pending events must not be acked while in reset
      @(negedge clk);
      ev8 = 8'hFF; mask8 = '0; err8 = '0; clr8 = 1'b0; if8.evt_ready = 1'b1;
      #1;
      chk("pre_rst_ack", 100, 32'(ack8), 32'h04);
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_valid", 101, 32'(if8.evt_valid), 32'h1);
      chk("pre_rst_id", 101, 32'(if8.evt_id), 32'h2);
      rstn = 1'b0;
      #1;
      chk("mid_rst_ack", 102, 32'(ack8), 32'h0);
      chk("mid_rst_valid", 102, 32'(if8.evt_valid), 32'h0);
      chk("mid_rst_id", 102, 32'(if8.evt_id), 32'h0);
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("post_rst_ack", 103, 32'(ack8), 32'h01);
      ev8 = '0;

      // Five-source build: pointer 4 wraps to 0
      @(negedge clk);
      ev5 = 5'b01000;
      #1;
      chk("n5_ack", 200, 32'(ack5), 32'h08);
      @(negedge clk);
      ev5 = 5'b10001;
      #1;
      chk("n5_ack", 201, 32'(ack5), 32'h10);
      chk("n5_id", 201, 32'(if5.evt_id), 32'h3);
      @(negedge clk);
      #1;
      chk("n5_ack", 202, 32'(ack5), 32'h01);
      chk("n5_id", 202, 32'(if5.evt_id), 32'h4);
      @(negedge clk);
      #1;
      chk("n5_ack", 203, 32'(ack5), 32'h10);
      chk("n5_id", 203, 32'(if5.evt_id), 32'h0);
      @(negedge clk);
      ev5 = '0;
      #1;
      chk("n5_ack", 204, 32'(ack5), 32'h00);
      chk("n5_id", 204, 32'(if5.evt_id), 32'h4);
      chk("n5_valid", 204, 32'(if5.evt_valid), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
